// File: rtl/deco_pkg.sv
// Shared widths, output type and idle-value helper for the 3-to-8 strobe decoder.
package deco_pkg;

  localparam int DEC_SEL_W = 3;
  localparam int DEC_OUT_W = 8;

  typedef logic [DEC_OUT_W-1:0] dec_out_t;

  // Idle means no strobe asserted, so the idle vector depends on output polarity.
  function automatic dec_out_t dec_idle(input bit active_low);
    return active_low ? {DEC_OUT_W{1'b1}} : {DEC_OUT_W{1'b0}};
  endfunction

endpackage

// File: rtl/deco_3to8_chk.sv
// Bind-able checker for deco_3to8: strobe vector is one-hot when enabled,
// idle when disabled, and idle after any reset edge.
module deco_3to8_chk
  import deco_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT        = 1'b1
) (
  input logic       clk,
  input logic       rst,
  input logic       x,
  input logic       y,
  input logic       z,
  input logic       en,
  input logic [7:0] o
);

  localparam dec_out_t IDLE = dec_idle(OUT_ACTIVE_LOW);

  logic armed_q;
  logic past_rst_q;
  logic past_en_q;

  // Checks start only after a reset has been seen, so power-up garbage is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
    end
    past_rst_q <= rst;
    past_en_q  <= en;

    if (en) begin
      assert (!$isunknown({x, y, z})) else $error("deco chk: unknown select while enabled");
    end

    if (REG_OUT) begin
      if (armed_q) begin
        if (past_rst_q) begin
          assert (o == IDLE) else $error("deco chk: output not idle after reset");
        end else if (past_en_q) begin
          assert ($onehot(o ^ IDLE)) else $error("deco chk: enabled output not one-hot");
        end else begin
          assert (o == IDLE) else $error("deco chk: disabled output not idle");
        end
      end
    end else begin
      if (en) begin
        assert ($onehot(o ^ IDLE)) else $error("deco chk: enabled output not one-hot");
      end else begin
        assert (o == IDLE) else $error("deco chk: disabled output not idle");
      end
    end
  end

endmodule

// File: rtl/deco_core.sv
// Combinational select+enable to one-hot core; active-high polarity, no state.
module deco_core
  import deco_pkg::*;
(
  input  logic [DEC_SEL_W-1:0] sel,
  input  logic                 en,
  output dec_out_t             dec
);

  always_comb begin
    dec = '0;
    if (en) begin
      dec[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/deco_3to8.sv
// Registered 3-to-8 strobe decoder with enable, optional output inversion and
// optional output register (1-cycle latency when registered, no handshake).
module deco_3to8
  import deco_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       en,
  output logic [7:0] o
);

  dec_out_t dec;
  dec_out_t dec_pol;
  dec_out_t o_d;

  deco_core u_core (
    .sel ({x, y, z}),
    .en  (en),
    .dec (dec)
  );

  always_comb begin
    dec_pol = OUT_ACTIVE_LOW ? ~dec : dec;
    // Reset forces idle ahead of any decode so o never shows a stale strobe.
    o_d     = rst ? dec_idle(OUT_ACTIVE_LOW) : dec_pol;
  end

  generate
    if (REG_OUT) begin : g_reg
      dec_out_t o_q;
      always_ff @(posedge clk) begin
        o_q <= o_d;
      end
      assign o = o_q;
    end else begin : g_comb
      assign o = dec_pol;
    end
  endgenerate

endmodule

// File: tb/tb_deco_3to8.sv
// Bench for deco_3to8: registered active-high, registered active-low and
// combinational instances driven by shared directed and random stimulus.
module tb_deco_3to8;

  logic       clk;
  logic       rst;
  logic       x, y, z, en;
  logic [7:0] o_a, o_b, o_c;

  int checks   = 0;
  int failures = 0;

  deco_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .o(o_a));
  deco_3to8 #(.OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .o(o_b));
  deco_3to8 #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .o(o_c));

  deco_3to8_chk #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) chk_a (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .o(o_a));
  deco_3to8_chk #(.OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) chk_b (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .o(o_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: strobe value = 2**select when enabled, captured one edge late.
  function automatic logic [7:0] strobe(input logic e, input int s);
    return e ? 8'(2 ** s) : 8'd0;
  endfunction

  logic [7:0] model_q;
  bit         model_vld = 1'b0;

  always @(posedge clk) begin
    model_q   = rst ? 8'd0 : strobe(en, int'({x, y, z}));
    model_vld = 1'b1;
  end

  always @(negedge clk) begin
    if (model_vld) begin
      checks++;
      if (o_a !== model_q) begin
        failures++;
        $display("FAIL model_a at %0t: got %h want %h", $time, o_a, model_q);
      end
      checks++;
      if (o_b !== ~model_q) begin
        failures++;
        $display("FAIL model_b at %0t: got %h want %h", $time, o_b, ~model_q);
      end
      checks++;
      if (o_c !== strobe(en, int'({x, y, z}))) begin
        failures++;
        $display("FAIL model_c at %0t: got %h want %h", $time, o_c, strobe(en, int'({x, y, z})));
      end
    end
  end

  // Apply inputs, let one edge pass, then land on the following falling edge.
  task automatic step(input logic r, input logic e, input logic [2:0] s);
    {x, y, z} = s;
    rst = r;
    en  = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [7:0] want);
    checks++;
    if (o_a !== want) begin
      failures++;
      $display("FAIL %s (active-high): got %h want %h", name, o_a, want);
    end
    checks++;
    if (o_b !== ~want) begin
      failures++;
      $display("FAIL %s (active-low): got %h want %h", name, o_b, ~want);
    end
  endtask

  logic [7:0] sweep_tbl [8];

  initial begin
    sweep_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst = 1'b1; en = 1'b1; {x, y, z} = 3'b101;

    step(1'b1, 1'b1, 3'b101); lit("reset_cycle1", 8'h00);
    step(1'b1, 1'b1, 3'b101); lit("reset_cycle2", 8'h00);
    step(1'b0, 1'b1, 3'b101); lit("first_decode", 8'h20);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 3'(i)); lit("disable_sweep", 8'h00);
    end

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(i)); lit("full_sweep", sweep_tbl[i]);
    end

    step(1'b0, 1'b1, 3'b011); lit("en_toggle_1", 8'h08);
    step(1'b0, 1'b0, 3'b011); lit("en_toggle_0", 8'h00);
    step(1'b0, 1'b1, 3'b011); lit("en_toggle_1b", 8'h08);

    for (int i = 4; i < 8; i++) begin
      step(i == 6, 1'b1, 3'(i));
      lit("mid_reset", (i == 6) ? 8'h00 : sweep_tbl[i]);
    end

    step(1'b0, 1'b1, 3'b000);
    checks++;
    if (o_b !== 8'hFE) begin
      failures++;
      $display("FAIL polarity_en: got %h want fe", o_b);
    end
    step(1'b0, 1'b0, 3'b000);
    checks++;
    if (o_b !== 8'hFF) begin
      failures++;
      $display("FAIL polarity_dis: got %h want ff", o_b);
    end

    // Combinational instance follows inputs within the same cycle.
    {x, y, z} = 3'b011; en = 1'b1; rst = 1'b1;
    #1;
    checks++;
    if (o_c !== 8'h08) begin
      failures++;
      $display("FAIL comb_ignores_reset: got %h want 08", o_c);
    end
    @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deco_3to8.md
Name: deco_3to8

Overview:
- Registered 3-to-8 binary decoder with active-high enable.
- Select is {x,y,z}, with x as the MSB.
- When enabled, exactly one output bit is asserted: the bit indexed by the select value. When disabled, all output bits are deasserted.
- Used as a small address/strobe decoder inside a synchronous datapath. The output is registered so downstream logic sees glitch-free strobes.

Parameters:
- OUT_ACTIVE_LOW, default 0. When 1, the whole output vector is inverted: the asserted bit is 0 and idle bits are 1. The reset value follows this polarity.
- REG_OUT, default 1. When 1, the output is registered with 1-cycle latency. When 0, the output is purely combinational, and the clock and reset affect nothing.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Reset. Synchronous and active-high.
- x  input  1  Select bit 2 (MSB).
- y  input  1  Select bit 1.
- z  input  1  Select bit 0 (LSB).
- en  input  1  Decode enable, active-high.
- o  output  8  Decoded one-hot strobe vector. o[i] corresponds to select value i.

Behaviour:
- Combinational core (polarity before OUT_ACTIVE_LOW is applied):
  - dec = en ? (8'b1 << {x,y,z}) : 8'h00.
- Output with REG_OUT=1:
  - o is updated on each rising clk edge from dec, or from ~dec when OUT_ACTIVE_LOW=1.
  - Latency is exactly 1 cycle from input change to o change.
  - No handshake. A new select/enable is accepted every cycle.
- Reset (REG_OUT=1):
  - While rst=1 at a rising edge, o loads the idle value: 8'h00, or 8'hFF when OUT_ACTIVE_LOW=1.
  - Reset takes priority over en and the select inputs.
  - Reset asserted mid-stream drops o to idle on the next edge. The first post-reset decode appears one edge after rst is deasserted.
- Invariants:
  - When en=1, exactly one bit of o is active. When en=0, no bit is active.
  - o is never multi-hot, including at any output reached after reset.
- Simultaneous changes: en and select changing in the same cycle are both reflected together on the next edge. No intermediate state is visible.
- X/Z on inputs: not required to be handled. Simulation assertion flags unknown select while en=1.
- No internal state beyond the output register.

Decomposition:
- Shared package deco_pkg:
  - constants DEC_SEL_W=3 and DEC_OUT_W=8;
  - typedef dec_out_t as logic [DEC_OUT_W-1:0];
  - function for the idle value as a function of polarity.
- Sub-module deco_core: combinational select+enable to one-hot. deco_3to8 instantiates deco_core and adds the polarity inversion and the optional output register.
- Assertions (one-hot/zero-hot check, reset value check) are kept in a bind-able checker, not in the RTL.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, {x,y,z}=3'b101 -> o=8'h00 throughout. After rst drops, o=8'h20 on the following edge.
- Disable: rst=0, en=0, sweep {x,y,z}=0..7 one per cycle -> o=8'h00 every cycle.
- Full sweep: en=1, {x,y,z}=0..7 one per cycle -> o=8'h01, 02, 04, 08, 10, 20, 40, 80, each lagging its input by exactly 1 cycle.
- Enable toggle: {x,y,z}=3'b011 held, en 1,0,1 on consecutive cycles -> o=8'h08, 8'h00, 8'h08.
- Mid-operation reset: en=1 sweeping values, assert rst for 1 cycle at value 6 -> o=8'h00 on that edge, then decode resumes with the current select.
- Polarity: OUT_ACTIVE_LOW=1, en=1, {x,y,z}=3'b000 -> o=8'hFE. en=0 -> o=8'hFF. Reset value -> o=8'hFF.
